// File: rtl/lzrw1_stream_sequencer.sv
// Parses an LZRW1 compressed byte stream into literal/copy items for decompressor_top.
// Optional LZRW1_HEADER_EN: 4-byte little-endian flag word precedes the stream.
module lzrw1_stream_sequencer #(
    parameter int unsigned LEN_W        = 16,
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned GUARD_CYCLES = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [LEN_W-1:0] stream_len,
    input  logic [7:0]       byte_in,
    input  logic             byte_in_valid,
    output logic             byte_in_ready,
    output logic [15:0]      dec_data_in,
    output logic             dec_control_word_in,
    output logic             dec_data_in_valid,
    input  logic             dec_busy,
    output logic             seq_busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] items_issued
);

    localparam int unsigned GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
    localparam logic [GW-1:0] GuardLast = GW'(GUARD_CYCLES - 1);
    localparam logic [LEN_W-1:0] RemOne = LEN_W'(1);

    typedef enum logic [3:0] {
        StIdle,
        StCwLo,
        StCwHi,
        StItemB0,
        StItemB1,
        StIssue,
        StGuard,
        StDone
`ifdef LZRW1_HEADER_EN
        ,
        StHdr0,
        StHdr1,
        StHdr2,
        StHdr3
`endif
    } state_e;

    state_e           state_q, state_d;
    logic [LEN_W-1:0] rem_q, rem_d;
    logic [15:0]      cw_q, cw_d;
    logic [3:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       b0_q, b0_d;
    logic [15:0]      data_q, data_d;
    logic             ctrl_q, ctrl_d;
    logic [CNT_W-1:0] items_q, items_d;
    logic             error_q, error_d;
    logic [GW-1:0]    guard_q, guard_d;
    logic             pop;
    logic             copy_mode;

`ifdef LZRW1_HEADER_EN
    logic [23:0] flag_q, flag_d;
    logic        copy_q, copy_d;
    logic [31:0] flag_word;
    assign copy_mode = copy_q;
    assign flag_word = {byte_in, flag_q};
`else
    assign copy_mode = 1'b0;
`endif

    assign pop = byte_in_valid && byte_in_ready;

    always_comb begin
        state_d       = state_q;
        rem_d         = rem_q;
        cw_d          = cw_q;
        bit_idx_d     = bit_idx_q;
        b0_d          = b0_q;
        data_d        = data_q;
        ctrl_d        = ctrl_q;
        items_d       = items_q;
        error_d       = error_q;
        guard_d       = guard_q;
        byte_in_ready = 1'b0;
`ifdef LZRW1_HEADER_EN
        flag_d        = flag_q;
        copy_d        = copy_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    rem_d     = stream_len;
                    error_d   = 1'b0;
                    items_d   = '0;
                    bit_idx_d = '0;
`ifdef LZRW1_HEADER_EN
                    copy_d = 1'b0;
                    if (stream_len < LEN_W'(4)) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StHdr0;
                    end
`else
                    state_d = (stream_len == '0) ? StDone : StCwLo;
`endif
                end
            end
`ifdef LZRW1_HEADER_EN
            StHdr0, StHdr1, StHdr2: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    rem_d = rem_q - RemOne;
                    unique case (state_q)
                        StHdr0: begin flag_d[7:0]   = byte_in; state_d = StHdr1; end
                        StHdr1: begin flag_d[15:8]  = byte_in; state_d = StHdr2; end
                        default: begin flag_d[23:16] = byte_in; state_d = StHdr3; end
                    endcase
                end
            end
            StHdr3: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    rem_d = rem_q - RemOne;
                    if (flag_word == 32'd1) begin
                        copy_d  = 1'b1;
                        state_d = (rem_q == RemOne) ? StDone : StItemB0;
                    end else if (flag_word == 32'd0) begin
                        state_d = (rem_q == RemOne) ? StDone : StCwLo;
                    end else begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end
                end
            end
`endif
            StCwLo: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    cw_d[7:0] = byte_in;
                    rem_d     = rem_q - RemOne;
                    // A lone low byte at stream end is a truncated control word.
                    if (rem_q == RemOne) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StCwHi;
                    end
                end
            end
            StCwHi: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    cw_d[15:8] = byte_in;
                    rem_d      = rem_q - RemOne;
                    bit_idx_d  = '0;
                    state_d    = (rem_q == RemOne) ? StDone : StItemB0;
                end
            end
            StItemB0: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    rem_d = rem_q - RemOne;
                    b0_d  = byte_in;
                    if (copy_mode || !cw_q[bit_idx_q]) begin
                        data_d  = {8'h00, byte_in};
                        ctrl_d  = 1'b0;
                        state_d = StIssue;
                    end else if (rem_q == RemOne) begin
                        error_d = 1'b1;
                        state_d = StDone;
                    end else begin
                        state_d = StItemB1;
                    end
                end
            end
            StItemB1: begin
                byte_in_ready = 1'b1;
                if (pop) begin
                    rem_d   = rem_q - RemOne;
                    data_d  = {b0_q, byte_in};
                    ctrl_d  = 1'b1;
                    state_d = StIssue;
                end
            end
            StIssue: begin
                if (!dec_busy) begin
                    if (items_q != '1) items_d = items_q + CNT_W'(1);
                    bit_idx_d = bit_idx_q + 4'd1;
                    guard_d   = '0;
                    state_d   = StGuard;
                end
            end
            StGuard: begin
                if (guard_q == GuardLast) begin
                    if (rem_q == '0) state_d = StDone;
                    else if (copy_mode) state_d = StItemB0;
                    else if (bit_idx_q == '0) state_d = StCwLo; // all 16 bits consumed
                    else state_d = StItemB0;
                end else begin
                    guard_d = guard_q + GW'(1);
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q   <= StIdle;
            rem_q     <= '0;
            cw_q      <= '0;
            bit_idx_q <= '0;
            b0_q      <= '0;
            data_q    <= '0;
            ctrl_q    <= 1'b0;
            items_q   <= '0;
            error_q   <= 1'b0;
            guard_q   <= '0;
`ifdef LZRW1_HEADER_EN
            flag_q    <= '0;
            copy_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            rem_q     <= rem_d;
            cw_q      <= cw_d;
            bit_idx_q <= bit_idx_d;
            b0_q      <= b0_d;
            data_q    <= data_d;
            ctrl_q    <= ctrl_d;
            items_q   <= items_d;
            error_q   <= error_d;
            guard_q   <= guard_d;
`ifdef LZRW1_HEADER_EN
            flag_q    <= flag_d;
            copy_q    <= copy_d;
`endif
        end
    end

    assign dec_data_in         = data_q;
    assign dec_control_word_in = ctrl_q;
    assign dec_data_in_valid   = (state_q == StIssue);
    assign seq_busy            = (state_q != StIdle);
    // Truncation/header errors also pass through DONE but must not pulse done.
    assign done                = (state_q == StDone) && !error_q;
    assign error               = error_q;
    assign items_issued        = items_q;

endmodule
